// File: rtl/mem_load_queue_pkg.sv
// Shared types and constants for the MEM-stage load return queue.
// Load opcodes, field widths, the per-entry metadata struct, and a small
// sign/zero extension helper used by the aligner.
// The optional lwl/lwr support is controlled by the macro MEM_LOAD_LWLR_EN.
package mem_load_queue_pkg;

  localparam int unsigned LOAD_OP_W = 3;
  localparam int unsigned OFF_W     = 2;
  localparam int unsigned RD_W      = 5;
  localparam int unsigned XLEN      = 32;

  localparam logic [LOAD_OP_W-1:0] LOAD_LB  = 3'd0;
  localparam logic [LOAD_OP_W-1:0] LOAD_LBU = 3'd1;
  localparam logic [LOAD_OP_W-1:0] LOAD_LH  = 3'd2;
  localparam logic [LOAD_OP_W-1:0] LOAD_LHU = 3'd3;
  localparam logic [LOAD_OP_W-1:0] LOAD_LW  = 3'd4;
  localparam logic [LOAD_OP_W-1:0] LOAD_LWL = 3'd5;
  localparam logic [LOAD_OP_W-1:0] LOAD_LWR = 3'd6;

  // Metadata captured when MEM hands a load to the queue.
  typedef struct packed {
    logic [LOAD_OP_W-1:0] op;
    logic [OFF_W-1:0]     off;
    logic [RD_W-1:0]      rd;
    logic [XLEN-1:0]      pc;
`ifdef MEM_LOAD_LWLR_EN
    logic [XLEN-1:0]      rt;
`endif
  } load_meta_t;

  // Extend an 8- or 16-bit quantity to XLEN; sgn selects sign extension.
  function automatic logic [XLEN-1:0] ext8(input logic [7:0] v, input logic sgn);
    return {{(XLEN-8){sgn & v[7]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] ext16(input logic [15:0] v, input logic sgn);
    return {{(XLEN-16){sgn & v[15]}}, v};
  endfunction

endpackage

// File: rtl/mem_load_queue_if.sv
// Bus between MEM/SRAM/WB and the load return queue.
// master: the pipeline side (drives requests, SRAM beats, WB ready, flush).
// slave : the queue (drives req_ready, wb_* results, occupancy, proto_err).
interface mem_load_queue_if #(
  parameter int unsigned DEPTH = 4
);
  import mem_load_queue_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                 flush;
  logic                 req_valid;
  logic                 req_ready;
  logic [LOAD_OP_W-1:0] req_op;
  logic [OFF_W-1:0]     req_off;
  logic [RD_W-1:0]      req_rd;
  logic [XLEN-1:0]      req_rt_data;
  logic [XLEN-1:0]      req_pc;
  logic                 rsp_valid;
  logic [XLEN-1:0]      rsp_data;
  logic                 wb_valid;
  logic                 wb_ready;
  logic [RD_W-1:0]      wb_rd;
  logic [XLEN-1:0]      wb_data;
  logic [XLEN-1:0]      wb_pc;
  logic [CNT_W-1:0]     outstanding;
  logic                 proto_err;

  modport master (
    output flush, req_valid, req_op, req_off, req_rd, req_rt_data, req_pc,
           rsp_valid, rsp_data, wb_ready,
    input  req_ready, wb_valid, wb_rd, wb_data, wb_pc, outstanding, proto_err
  );

  modport slave (
    input  flush, req_valid, req_op, req_off, req_rd, req_rt_data, req_pc,
           rsp_valid, rsp_data, wb_ready,
    output req_ready, wb_valid, wb_rd, wb_data, wb_pc, outstanding, proto_err
  );

endinterface

// File: rtl/mem_load_align.sv
// Combinational load aligner: selects and extends the addressed byte/half,
// or merges the SRAM word with the old rt value for lwl/lwr (little endian).
// Ports: op, off (addr[1:0]), raw (SRAM word), rt (old rt value) -> result.
// Kept standalone so a future store-forward path can reuse it.
module mem_load_align
  import mem_load_queue_pkg::*;
(
  input  logic [LOAD_OP_W-1:0] op,
  input  logic [OFF_W-1:0]     off,
  input  logic [XLEN-1:0]      raw,
  input  logic [XLEN-1:0]      rt,
  output logic [XLEN-1:0]      result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte/half lane selection.
  always_comb begin
    byte_sel = raw[7:0];
    case (off)
      2'd0: byte_sel = raw[7:0];
      2'd1: byte_sel = raw[15:8];
      2'd2: byte_sel = raw[23:16];
      2'd3: byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase
    half_sel = off[1] ? raw[31:16] : raw[15:0];
  end

  // Opcode decode; misaligned halves and unknown ops return zero.
  always_comb begin
    result = '0;
    case (op)
      LOAD_LB:  result = ext8(byte_sel, 1'b1);
      LOAD_LBU: result = ext8(byte_sel, 1'b0);
      LOAD_LH:  result = off[0] ? '0 : ext16(half_sel, 1'b1);
      LOAD_LHU: result = off[0] ? '0 : ext16(half_sel, 1'b0);
      LOAD_LW:  result = raw;
      LOAD_LWL: begin
        case (off)
          2'd0: result = {raw[7:0],  rt[23:0]};
          2'd1: result = {raw[15:0], rt[15:0]};
          2'd2: result = {raw[23:0], rt[7:0]};
          default: result = raw;
        endcase
      end
      LOAD_LWR: begin
        case (off)
          2'd0: result = raw;
          2'd1: result = {rt[31:24], raw[31:8]};
          2'd2: result = {rt[31:16], raw[31:16]};
          default: result = {rt[31:8], raw[31:24]};
        endcase
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_load_queue.sv
// MEM-stage load return queue: DEPTH-entry in-order circular buffer pairing
// load metadata with variable-latency SRAM beats, aligning the head result
// and handing it to WB over valid/ready. Flushed loads' beats are dropped.
// Ports: clk, rst (sync, active-high), bus (mem_load_queue_if.slave) carrying
//   flush, req_* (load in), rsp_* (SRAM beat), wb_* (result out),
//   outstanding (occupancy) and proto_err (sticky spurious-beat flag).
// Macro MEM_LOAD_LWLR_EN: enables lwl/lwr and per-entry rt storage; without
// it lwl/lwr return 0 and req_rt_data is ignored.
module mem_load_queue
  import mem_load_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_load_queue_if.slave    bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr, fill_ptr, rd_ptr;
  logic [CNT_W-1:0] count, unf_cnt, drop_cnt;
  logic [DEPTH-1:0] filled;
  logic             proto_err_q;

  load_meta_t       meta_q [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];

  logic             req_ready_c;
  logic             accept, fill, spurious, pop, head_valid;
  logic [CNT_W-1:0] drop_pend;
  load_meta_t       head_meta, new_meta;
  logic [XLEN-1:0]  head_rt, align_res;
  logic             head_lwlr;

  // Handshake decode. unf_cnt (accepted but unfilled) disambiguates
  // fill_ptr == wr_ptr and excludes a same-cycle accept from filling.
  always_comb begin
    req_ready_c = (count != CNT_W'(DEPTH)) && (drop_cnt == '0);
    accept      = bus.req_valid && req_ready_c;
    fill        = bus.rsp_valid && (drop_cnt == '0) && (unf_cnt != '0);
    spurious    = bus.rsp_valid && (drop_cnt == '0) && (unf_cnt == '0);
    head_valid  = filled[rd_ptr];
    pop         = head_valid && bus.wb_ready;
  end

  // Beats still owed by the SRAM after a flush, less one landing this cycle.
  always_comb begin
    drop_pend = drop_cnt + unf_cnt;
    if (bus.rsp_valid && (drop_pend != '0)) drop_pend = drop_pend - CNT_W'(1);
  end

  // Pointers, occupancy, drop counter and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      fill_ptr    <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      unf_cnt     <= '0;
      drop_cnt    <= '0;
      filled      <= '0;
      proto_err_q <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      unf_cnt  <= '0;
      filled   <= '0;
      drop_cnt <= drop_pend;
      if (spurious) proto_err_q <= 1'b1;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fill) begin
        filled[fill_ptr] <= 1'b1;
        fill_ptr         <= fill_ptr + PTR_W'(1);
      end
      // A pop never targets fill_ptr: the head is filled, fill_ptr is not.
      if (pop) begin
        filled[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + PTR_W'(1);
      end
      count   <= count + CNT_W'(accept) - CNT_W'(pop);
      unf_cnt <= unf_cnt + CNT_W'(accept) - CNT_W'(fill);
      if (bus.rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_W'(1);
      if (spurious) proto_err_q <= 1'b1;
    end
  end

  always_comb begin
    new_meta     = '0;
    new_meta.op  = bus.req_op;
    new_meta.off = bus.req_off;
    new_meta.rd  = bus.req_rd;
    new_meta.pc  = bus.req_pc;
`ifdef MEM_LOAD_LWLR_EN
    new_meta.rt  = bus.req_rt_data;
`endif
  end

  // Entry payload storage; contents only matter once filled/valid.
  always_ff @(posedge clk) begin
    if (accept) meta_q[wr_ptr] <= new_meta;
    if (fill)   data_q[fill_ptr] <= bus.rsp_data;
  end

  assign head_meta = meta_q[rd_ptr];

`ifdef MEM_LOAD_LWLR_EN
  assign head_rt   = head_meta.rt;
  assign head_lwlr = 1'b0;
`else
  logic unused_rt;
  assign unused_rt = ^bus.req_rt_data;
  assign head_rt   = '0;
  assign head_lwlr = (head_meta.op == LOAD_LWL) || (head_meta.op == LOAD_LWR);
`endif

  mem_load_align u_align (
    .op     (head_meta.op),
    .off    (head_meta.off),
    .raw    (data_q[rd_ptr]),
    .rt     (head_rt),
    .result (align_res)
  );

  // WB outputs follow the head entry and read as zero when it is not filled.
  always_comb begin
    bus.req_ready   = req_ready_c;
    bus.wb_valid    = head_valid;
    bus.wb_rd       = head_valid ? head_meta.rd : '0;
    bus.wb_pc       = head_valid ? head_meta.pc : '0;
    bus.wb_data     = (head_valid && !head_lwlr) ? align_res : '0;
    bus.outstanding = count;
    bus.proto_err   = proto_err_q;
  end

endmodule
